fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the SISC control FSM. It holds the PC and the instruction register (IR).
- It applies ctrl's pc_write/pc_sel/br_sel/pc_rst/ir_load commands and runs a req/ack handshake to instruction memory.
- It decodes IR fields (opcode, mm, register fields, imm) that ctrl and the datapath consume.
- It raises fetch_busy while an IR load is outstanding, and substitutes NOOP on a memory timeout.

Parameters:
ADDR_W, 16, PC / instruction-address width
INSTR_W, 32, instruction width
TIMEOUT, 15, max cycles waiting for imem_ack before NOOP substitution (1..255)
NOOP_WORD, 32'h0000_0000, word loaded into IR on timeout or reset

Ports:
clk  in  1  system clock, all state updates on posedge
rst_f  in  1  reset, asynchronous, active-low
pc_rst  in  1  synchronous PC/IR clear from ctrl
pc_write  in  1  update PC this edge
pc_sel  in  1  0 = PC+1, 1 = branch target
br_sel  in  1  1 = absolute target (imm), 0 = relative (PC+imm)
ir_load  in  1  start instruction fetch from current PC
imem_addr  out  ADDR_W  fetch address, stable while imem_req is high
imem_req  out  1  fetch request
imem_rdata  in  INSTR_W  instruction word, valid when imem_ack is high
imem_ack  in  1  request completion, sampled only while imem_req is high
pc_out  out  ADDR_W  current PC
ir  out  INSTR_W  instruction register
opcode  out  4  ir[31:28]
mm  out  4  ir[27:24]
rd  out  4  ir[23:20]
rs  out  4  ir[19:16]
imm  out  16  ir[15:0]
fetch_busy  out  1  fetch outstanding
fetch_err  out  1  sticky; set on timeout

Behaviour:
- rst_f low, asynchronous:
  - pc_out=0, ir=NOOP_WORD, imem_req=0, imem_addr=0, fetch_busy=0, fetch_err=0, timeout counter=0.
  - FSM goes to IDLE.
- Priority at each posedge: pc_rst > fetch completion/timeout > pc_write > ir_load.
- pc_rst=1:
  - pc_out<=0, ir<=NOOP_WORD, imem_req<=0, FSM<=IDLE.
  - Any outstanding fetch is aborted; fetch_err is not cleared.
- PC update when pc_write=1:
  - pc_sel=0: PC<=PC+1.
  - pc_sel=1, br_sel=1: PC<=imm.
  - pc_sel=1, br_sel=0: PC<=PC+imm.
  - All arithmetic is modulo 2^ADDR_W, with imm treated as unsigned.
  - imm is taken from the current IR.
  - pc_write is honoured in every FSM state.
- FSM states: IDLE, WAIT.
  - IDLE & ir_load=1: imem_addr<=PC (the pre-update value, even if pc_write is asserted the same edge); imem_req<=1; fetch_busy<=1; counter<=0; go to WAIT.
  - WAIT & imem_ack=1: ir<=imem_rdata; imem_req<=0; fetch_busy<=0; go to IDLE. The IR updates on the same edge ack is sampled.
  - WAIT & !ack & counter==TIMEOUT-1: ir<=NOOP_WORD; fetch_err<=1; imem_req<=0; fetch_busy<=0; go to IDLE.
  - WAIT otherwise: counter++; imem_addr is held.
  - ir_load while in WAIT is ignored; no queueing.
- Latency: ir_load sampled at edge N puts imem_req high after N. An ack present at edge N+k (k>=1) makes IR valid after edge N+k. Minimum fetch is 2 edges.
- imem_ack while imem_req=0 is ignored.
- Field outputs (opcode, mm, rd, rs, imm) are combinational slices of the IR register.
- An imem_ack arriving on the timeout edge wins: IR takes the data, and fetch_err is not set.

Decomposition:
- Shared package `sisc_pkg`:
  - opcode constants (NOOP=0, LOD=1, STR=2, SWP=3, BRA=4, BRR=5, BNE=6, BNR=7, ALU_OP=8, HLT=15);
  - IR field bit positions;
  - am_imm=8;
  - NOOP_WORD.
- One natural sub-module, `pc_next`: the purely combinational next-PC mux/adder (pc, imm, pc_sel, br_sel -> next_pc). The FSM and registers stay in fetch_unit.

Test Plan:
- Reset: drop rst_f mid-cycle with PC=0x0042 and a fetch outstanding -> immediately pc_out=0, ir=0, imem_req=0, fetch_busy=0.
- Sequential fetch: PC=0x0010, pulse ir_load+pc_write (pc_sel=0) together, imem_ack 2 cycles after req with rdata=0x8123_0005 -> imem_addr=0x0010, PC=0x0011, ir=0x81230005, opcode=8, mm=1, imm=0x0005, busy low after the ack edge.
- Absolute branch: ir imm=0x0300, pc_write, pc_sel=1, br_sel=1 -> pc_out=0x0300. Relative wrap: PC=0xFFFE, imm=0x0005, br_sel=0 -> pc_out=0x0003.
- Timeout: ir_load with no ack, TIMEOUT=15 -> after 15 WAIT cycles ir=0x00000000, fetch_err=1 (sticky through a later successful fetch), imem_req=0.
- pc_rst mid-fetch: ir_load, then pc_rst in cycle 2 of WAIT, then a late imem_ack -> ack ignored, pc_out=0, ir=NOOP, FSM IDLE.
- ir_load during WAIT plus simultaneous ack/timeout edge: second ir_load ignored (one request only); ack on the timeout edge loads data with fetch_err unchanged.

Source files
------------

// File: rtl/sisc_pkg.sv
// Shared SISC definitions: opcodes, instruction-word field positions and the NOOP encoding.
package sisc_pkg;

  typedef enum logic [3:0] {
    NOOP   = 4'd0,
    LOD    = 4'd1,
    STR    = 4'd2,
    SWP    = 4'd3,
    BRA    = 4'd4,
    BRR    = 4'd5,
    BNE    = 4'd6,
    BNR    = 4'd7,
    ALU_OP = 4'd8,
    HLT    = 4'd15
  } opcode_t;

  localparam int OPCODE_HI = 31;
  localparam int OPCODE_LO = 28;
  localparam int MM_HI     = 27;
  localparam int MM_LO     = 24;
  localparam int RD_HI     = 23;
  localparam int RD_LO     = 20;
  localparam int RS_HI     = 19;
  localparam int RS_LO     = 16;
  localparam int IMM_HI    = 15;
  localparam int IMM_LO    = 0;

  localparam logic [3:0]  AM_IMM    = 4'd8;
  localparam logic [31:0] NOOP_WORD = 32'h0000_0000;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage and imem.
interface fetch_unit_if #(
  parameter int ADDR_W  = 16,
  parameter int INSTR_W = 32
);
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_req;
  logic [INSTR_W-1:0] imem_rdata;
  logic               imem_ack;

  modport master (
    output imem_addr,
    output imem_req,
    input  imem_rdata,
    input  imem_ack
  );

  modport slave (
    input  imem_addr,
    input  imem_req,
    output imem_rdata,
    output imem_ack
  );
endinterface

// File: rtl/fetch_unit_pc_next.sv
// Combinational next-PC selection: sequential increment, absolute target or PC-relative target.
module pc_next #(
  parameter int ADDR_W = 16
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic [15:0]       imm,
  input  logic              pc_sel,
  input  logic              br_sel,
  output logic [ADDR_W-1:0] next_pc
);

  logic [ADDR_W-1:0] imm_ext;

  // imm is unsigned; sums wrap modulo 2^ADDR_W
  always_comb begin
    imm_ext = ADDR_W'(imm);
    if (!pc_sel) begin
      next_pc = pc + ADDR_W'(1'b1);
    end else if (br_sel) begin
      next_pc = imm_ext;
    end else begin
      next_pc = pc + imm_ext;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// SISC instruction-fetch stage: PC and IR registers, imem req/ack handshake with timeout
// NOOP substitution, and IR field decode for the control FSM and datapath.
module fetch_unit #(
  parameter int                 ADDR_W    = 16,
  parameter int                 INSTR_W   = 32,
  parameter int                 TIMEOUT   = 15,
  parameter logic [INSTR_W-1:0] NOOP_WORD = sisc_pkg::NOOP_WORD
) (
  input  logic               clk,
  input  logic               rst_f,
  input  logic               pc_rst,
  input  logic               pc_write,
  input  logic               pc_sel,
  input  logic               br_sel,
  input  logic               ir_load,
  fetch_unit_if.master       imem,
  output logic [ADDR_W-1:0]  pc_out,
  output logic [INSTR_W-1:0] ir,
  output logic [3:0]         opcode,
  output logic [3:0]         mm,
  output logic [3:0]         rd,
  output logic [3:0]         rs,
  output logic [15:0]        imm,
  output logic               fetch_busy,
  output logic               fetch_err
);
  import sisc_pkg::*;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  fetch_state_t       state_r, state_nxt;
  logic [ADDR_W-1:0]  pc_r, pc_nxt, addr_r, addr_nxt, pc_calc;
  logic [INSTR_W-1:0] ir_r, ir_nxt;
  logic               req_r, req_nxt;
  logic               busy_r, busy_nxt;
  logic               err_r, err_nxt;
  logic [7:0]         cnt_r, cnt_nxt;

  pc_next #(.ADDR_W(ADDR_W)) u_pc_next (
    .pc      (pc_r),
    .imm     (ir_r[IMM_HI:IMM_LO]),
    .pc_sel  (pc_sel),
    .br_sel  (br_sel),
    .next_pc (pc_calc)
  );

  // Next-state and next-register values; pc_rst overrides everything except the sticky error
  always_comb begin
    state_nxt = state_r;
    pc_nxt    = pc_r;
    addr_nxt  = addr_r;
    ir_nxt    = ir_r;
    req_nxt   = req_r;
    busy_nxt  = busy_r;
    err_nxt   = err_r;
    cnt_nxt   = cnt_r;
    if (pc_rst) begin
      state_nxt = ST_IDLE;
      pc_nxt    = {ADDR_W{1'b0}};
      ir_nxt    = NOOP_WORD;
      req_nxt   = 1'b0;
      busy_nxt  = 1'b0;
      cnt_nxt   = 8'd0;
    end else begin
      if (pc_write) begin
        pc_nxt = pc_calc;
      end else begin
        pc_nxt = pc_r;
      end
      case (state_r)
        ST_IDLE: begin
          if (ir_load) begin
            state_nxt = ST_WAIT;
            addr_nxt  = pc_r;
            req_nxt   = 1'b1;
            busy_nxt  = 1'b1;
            cnt_nxt   = 8'd0;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
        ST_WAIT: begin
          // an ack on the timeout edge wins over the timeout
          if (imem.imem_ack) begin
            state_nxt = ST_IDLE;
            ir_nxt    = imem.imem_rdata;
            req_nxt   = 1'b0;
            busy_nxt  = 1'b0;
          end else if (cnt_r == TO_LAST) begin
            state_nxt = ST_IDLE;
            ir_nxt    = NOOP_WORD;
            err_nxt   = 1'b1;
            req_nxt   = 1'b0;
            busy_nxt  = 1'b0;
          end else begin
            state_nxt = ST_WAIT;
            cnt_nxt   = cnt_r + 8'd1;
          end
        end
        default: begin
          state_nxt = ST_IDLE;
          req_nxt   = 1'b0;
          busy_nxt  = 1'b0;
        end
      endcase
    end
  end

  // State and register update with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      state_r <= ST_IDLE;
      pc_r    <= {ADDR_W{1'b0}};
      addr_r  <= {ADDR_W{1'b0}};
      ir_r    <= NOOP_WORD;
      req_r   <= 1'b0;
      busy_r  <= 1'b0;
      err_r   <= 1'b0;
      cnt_r   <= 8'd0;
    end else begin
      state_r <= state_nxt;
      pc_r    <= pc_nxt;
      addr_r  <= addr_nxt;
      ir_r    <= ir_nxt;
      req_r   <= req_nxt;
      busy_r  <= busy_nxt;
      err_r   <= err_nxt;
      cnt_r   <= cnt_nxt;
    end
  end

  assign imem.imem_addr = addr_r;
  assign imem.imem_req  = req_r;
  assign pc_out         = pc_r;
  assign ir             = ir_r;
  assign opcode         = ir_r[OPCODE_HI:OPCODE_LO];
  assign mm             = ir_r[MM_HI:MM_LO];
  assign rd             = ir_r[RD_HI:RD_LO];
  assign rs             = ir_r[RS_HI:RS_LO];
  assign imm            = ir_r[IMM_HI:IMM_LO];
  assign fetch_busy     = busy_r;
  assign fetch_err      = err_r;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table, hand-written corner sequences,
// and random stimulus compared against a transaction-level reference model.
module tb_fetch_unit;

  localparam int TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        rst_f;
  logic        pc_rst, pc_write, pc_sel, br_sel, ir_load;
  logic [15:0] pc_out;
  logic [31:0] ir;
  logic [3:0]  opcode, mm, rd, rs;
  logic [15:0] imm;
  logic        fetch_busy, fetch_err;

  int checks = 0;
  int errors = 0;

  fetch_unit_if #(.ADDR_W(16), .INSTR_W(32)) imem ();

  fetch_unit #(.ADDR_W(16), .INSTR_W(32), .TIMEOUT(TIMEOUT), .NOOP_WORD(32'h0000_0000)) dut (
    .clk        (clk),
    .rst_f      (rst_f),
    .pc_rst     (pc_rst),
    .pc_write   (pc_write),
    .pc_sel     (pc_sel),
    .br_sel     (br_sel),
    .ir_load    (ir_load),
    .imem       (imem),
    .pc_out     (pc_out),
    .ir         (ir),
    .opcode     (opcode),
    .mm         (mm),
    .rd         (rd),
    .rs         (rs),
    .imm        (imm),
    .fetch_busy (fetch_busy),
    .fetch_err  (fetch_err)
  );

  always #5 clk = ~clk;

  // Reference model: a pending fetch is a record with the edge number it started on.
  logic [15:0] m_pc, m_addr;
  logic [31:0] m_ir;
  logic        m_err, m_pending;
  int          m_start, edge_no = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 16'h0000; m_addr = 16'h0000; m_ir = 32'h0000_0000;
    m_err = 1'b0; m_pending = 1'b0; m_start = 0;
  endtask

  task automatic model_step(input logic rst_i, wr, sel, bsel, ld, ack, input logic [31:0] rdata);
    logic [15:0] target;
    edge_no++;
    if (!sel) target = m_pc + 16'd1;
    else if (bsel) target = m_ir[15:0];
    else target = m_pc + m_ir[15:0];
    if (rst_i) begin
      m_pc = 16'h0000; m_ir = 32'h0000_0000; m_pending = 1'b0;
    end else begin
      if (m_pending) begin
        if (ack) begin
          m_ir = rdata; m_pending = 1'b0;
        end else if (edge_no - m_start == TIMEOUT) begin
          m_ir = 32'h0000_0000; m_err = 1'b1; m_pending = 1'b0;
        end
      end else if (ld) begin
        m_pending = 1'b1; m_start = edge_no; m_addr = m_pc;
      end
      if (wr) m_pc = target;
    end
  endtask

  task automatic compare_model();
    chk("m_pc", 32'(pc_out), 32'(m_pc));
    chk("m_ir", ir, m_ir);
    chk("m_req", 32'(imem.imem_req), 32'(m_pending));
    chk("m_busy", 32'(fetch_busy), 32'(m_pending));
    chk("m_err", 32'(fetch_err), 32'(m_err));
    if (m_pending) chk("m_addr", 32'(imem.imem_addr), 32'(m_addr));
    chk("m_fields", {opcode, mm, rd, rs, imm}, m_ir);
  endtask

  task automatic step(input logic rst_i, wr, sel, bsel, ld, ack, input logic [31:0] rdata);
    pc_rst = rst_i; pc_write = wr; pc_sel = sel; br_sel = bsel; ir_load = ld;
    imem.imem_ack = ack; imem.imem_rdata = rdata;
    model_step(rst_i, wr, sel, bsel, ld, ack, rdata);
    @(posedge clk);
    #1;
    compare_model();
  endtask

  task automatic idle(); step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0); endtask
  task automatic load(); step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0); endtask
  task automatic ack_with(input logic [31:0] d); step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, d); endtask
  task automatic jump_abs(); step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0); endtask

  task automatic hard_reset();
    rst_f = 1'b0;
    pc_rst = 1'b0; pc_write = 1'b0; pc_sel = 1'b0; br_sel = 1'b0; ir_load = 1'b0;
    imem.imem_ack = 1'b0; imem.imem_rdata = 32'h0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_f = 1'b1;
  endtask

  typedef struct {
    logic        rst, wr, sel, bsel, ld, ack;
    logic [31:0] rdata;
    logic [15:0] pc;
    logic [31:0] ir;
    logic        req, busy, err;
    logic [15:0] addr;
  } vec_t;

  vec_t tbl[$];

  initial begin
    // rst wr sel bsel ld ack rdata | pc ir req busy err addr
    tbl.push_back('{1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,32'h0,         16'h0000,32'h0000_0000,1'b1,1'b1,1'b0,16'h0000});
    tbl.push_back('{1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,32'h0000_0010, 16'h0000,32'h0000_0010,1'b0,1'b0,1'b0,16'h0000});
    tbl.push_back('{1'b0,1'b1,1'b1,1'b1,1'b0,1'b0,32'h0,         16'h0010,32'h0000_0010,1'b0,1'b0,1'b0,16'h0000});
    tbl.push_back('{1'b0,1'b1,1'b0,1'b0,1'b1,1'b0,32'h0,         16'h0011,32'h0000_0010,1'b1,1'b1,1'b0,16'h0010});
    tbl.push_back('{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,         16'h0011,32'h0000_0010,1'b1,1'b1,1'b0,16'h0010});
    tbl.push_back('{1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,32'h8123_0005, 16'h0011,32'h8123_0005,1'b0,1'b0,1'b0,16'h0000});
    tbl.push_back('{1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,32'h0,         16'h0016,32'h8123_0005,1'b0,1'b0,1'b0,16'h0000});
    tbl.push_back('{1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,32'h0,         16'h0016,32'h8123_0005,1'b1,1'b1,1'b0,16'h0016});
    tbl.push_back('{1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,32'h4000_0300, 16'h0016,32'h4000_0300,1'b0,1'b0,1'b0,16'h0000});
    tbl.push_back('{1'b0,1'b1,1'b1,1'b1,1'b0,1'b0,32'h0,         16'h0300,32'h4000_0300,1'b0,1'b0,1'b0,16'h0000});
    tbl.push_back('{1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,32'h0,         16'h0300,32'h4000_0300,1'b1,1'b1,1'b0,16'h0300});
    tbl.push_back('{1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,32'h4000_FFFE, 16'h0300,32'h4000_FFFE,1'b0,1'b0,1'b0,16'h0000});
    tbl.push_back('{1'b0,1'b1,1'b1,1'b1,1'b0,1'b0,32'h0,         16'hFFFE,32'h4000_FFFE,1'b0,1'b0,1'b0,16'h0000});
    tbl.push_back('{1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,32'h0,         16'hFFFE,32'h4000_FFFE,1'b1,1'b1,1'b0,16'hFFFE});
    tbl.push_back('{1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,32'h5000_0005, 16'hFFFE,32'h5000_0005,1'b0,1'b0,1'b0,16'h0000});
    tbl.push_back('{1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,32'h0,         16'h0003,32'h5000_0005,1'b0,1'b0,1'b0,16'h0000});
    tbl.push_back('{1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,32'hDEAD_BEEF, 16'h0003,32'h5000_0005,1'b0,1'b0,1'b0,16'h0000});

    hard_reset();
    chk("reset_pc", 32'(pc_out), 32'h0);
    chk("reset_ir", ir, 32'h0);
    chk("reset_req", 32'(imem.imem_req), 32'h0);
    chk("reset_busy", 32'(fetch_busy), 32'h0);
    chk("reset_err", 32'(fetch_err), 32'h0);

    // Directed table: sequential fetch, absolute branch, relative wrap, stray ack
    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].rst, tbl[i].wr, tbl[i].sel, tbl[i].bsel, tbl[i].ld, tbl[i].ack, tbl[i].rdata);
      chk($sformatf("tbl%0d_pc", i), 32'(pc_out), 32'(tbl[i].pc));
      chk($sformatf("tbl%0d_ir", i), ir, tbl[i].ir);
      chk($sformatf("tbl%0d_req", i), 32'(imem.imem_req), 32'(tbl[i].req));
      chk($sformatf("tbl%0d_busy", i), 32'(fetch_busy), 32'(tbl[i].busy));
      chk($sformatf("tbl%0d_err", i), 32'(fetch_err), 32'(tbl[i].err));
      chk($sformatf("tbl%0d_fields", i), {opcode, mm, rd, rs, imm}, tbl[i].ir);
      if (tbl[i].req) chk($sformatf("tbl%0d_addr", i), 32'(imem.imem_addr), 32'(tbl[i].addr));
    end

    // Timeout: no ack for 15 WAIT edges substitutes NOOP and sets the sticky error
    load();
    repeat (TIMEOUT - 1) idle();
    chk("to_still_busy", 32'(fetch_busy), 32'h1);
    chk("to_still_req", 32'(imem.imem_req), 32'h1);
    idle();
    chk("to_ir_noop", ir, 32'h0);
    chk("to_err", 32'(fetch_err), 32'h1);
    chk("to_req_low", 32'(imem.imem_req), 32'h0);
    load();
    ack_with(32'h2345_6789);
    chk("to_after_ir", ir, 32'h2345_6789);
    chk("to_err_sticky", 32'(fetch_err), 32'h1);

    // pc_rst in the second WAIT cycle aborts the fetch; the late ack is ignored
    jump_abs();
    chk("pr_pc_pre", 32'(pc_out), 32'h6789);
    load();
    idle();
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    ack_with(32'hFFFF_FFFF);
    chk("pr_pc", 32'(pc_out), 32'h0);
    chk("pr_ir", ir, 32'h0);
    chk("pr_req", 32'(imem.imem_req), 32'h0);
    chk("pr_busy", 32'(fetch_busy), 32'h0);
    chk("pr_err_kept", 32'(fetch_err), 32'h1);

    // Asynchronous reset mid-cycle with PC=0x0042 and a fetch outstanding
    load();
    ack_with(32'h0000_0042);
    jump_abs();
    load();
    chk("ar_pre_pc", 32'(pc_out), 32'h0042);
    chk("ar_pre_req", 32'(imem.imem_req), 32'h1);
    #3;
    rst_f = 1'b0;
    #1;
    chk("ar_pc", 32'(pc_out), 32'h0);
    chk("ar_ir", ir, 32'h0);
    chk("ar_req", 32'(imem.imem_req), 32'h0);
    chk("ar_busy", 32'(fetch_busy), 32'h0);
    chk("ar_err", 32'(fetch_err), 32'h0);
    model_reset();
    @(posedge clk);
    #1;
    rst_f = 1'b1;

    // Held ir_load during WAIT is ignored; an ack on the timeout edge wins
    load();
    repeat (TIMEOUT - 1) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'hA5A5_1234);
    chk("te_ir", ir, 32'hA5A5_1234);
    chk("te_err", 32'(fetch_err), 32'h0);
    chk("te_req", 32'(imem.imem_req), 32'h0);
    idle();
    chk("te_no_queue", 32'(imem.imem_req), 32'h0);

    // Random stimulus against the reference model
    for (int n = 0; n < 800; n++) begin
      step(($urandom_range(31) == 0), ($urandom_range(3) == 0), 1'($urandom()), 1'($urandom()),
           ($urandom_range(2) == 0), ($urandom_range(4) == 0), $urandom());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
